// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg                                                              |
// | Shared constants, glyph table and types for the 7-segment capture.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package seg_pkg;

  localparam int NUM_DIG = 4;

  localparam logic [6:0] BLANK_CODE = 7'h00;
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [4*NUM_DIG-1:0] value;
    logic [NUM_DIG-1:0]   dp;
    logic [NUM_DIG-1:0]   blank;
  } frame_t;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
  endfunction

  // Only meaningful for a one-hot select; anything else maps to slot 0.
  function automatic logic [1:0] sel_index(input logic [NUM_DIG-1:0] sel);
    case (sel)
      4'b0010: sel_index = 2'd1;
      4'b0100: sel_index = 2'd2;
      4'b1000: sel_index = 2'd3;
      default: sel_index = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_decode                                                          |
// | Combinational 7-segment pattern to hex nibble / blank / illegal.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       illegal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    illegal = 1'b0;
    blank   = 1'b0;
    nibble  = 4'h0;
    if (seg == BLANK_CODE) begin
      blank = 1'b1;
    end else begin
      illegal = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (seg == glyph(4'(i))) begin
          illegal = 1'b0;
          nibble  = 4'(i);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_capture                                                     |
// | Recovers the hex value shown on a multiplexed 4-digit 7-seg bus.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYC    = 16,
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned TIMEOUT_CYC   = 2_000_000,
  parameter bit          SEG_ACT_LOW   = 1'b1,
  parameter bit          DIG_ACT_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  smg,
  input  logic [3:0]  dig,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic        valid,
  output logic        err,
  output logic        lost
);

  localparam int unsigned       LOST_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LOST_W-1:0] LOST_MAX    = LOST_W'(TIMEOUT_CYC);
  localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [3:0]        MATCH_MAX   = 4'(STABLE_FRAMES);

  logic [NUM_DIG-1:0] sel_s1_q, sel_s1_d, sel_s2_q;
  logic [7:0]         seg_s1_q, seg_s1_d, seg_s2_q;

  scan_state_e        state_q, state_d;
  logic [NUM_DIG-1:0] cur_sel_q, cur_sel_d;
  logic [15:0]        settle_cnt_q, settle_cnt_d;
  logic [NUM_DIG-1:0] mask_q, mask_d;
  logic               bad_q, bad_d;
  frame_t             frame_q, frame_d;
  frame_t             prev_q, prev_d;
  logic [3:0]         match_cnt_q, match_cnt_d;
  logic               pub_flag_q, pub_flag_d;
  frame_t             out_q, out_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [LOST_W-1:0]  lost_cnt_q, lost_cnt_d;
  logic               lost_q, lost_d;

  logic [NUM_DIG-1:0] sel;
  logic               multi_hot;
  logic [1:0]         idx;
  logic               sample;
  logic               bad_now;
  logic [NUM_DIG-1:0] mask_now;
  logic [3:0]         match_nx;
  logic               dec_illegal;
  logic               dec_blank;
  logic [3:0]         dec_nibble;

  always_comb begin
    sel_s1_d = DIG_ACT_LOW ? ~dig : dig;
    seg_s1_d = SEG_ACT_LOW ? ~smg : smg;
  end

  assign sel       = sel_s2_q;
  assign multi_hot = |(sel & (sel - 4'd1));
  assign idx       = sel_index(cur_sel_q);

  seg7_decode u_decode (
    .seg     (seg_s2_q[6:0]),
    .illegal (dec_illegal),
    .blank   (dec_blank),
    .nibble  (dec_nibble)
  );

  always_comb begin
    state_d      = state_q;
    cur_sel_d    = cur_sel_q;
    settle_cnt_d = settle_cnt_q;
    mask_d       = mask_q;
    bad_d        = bad_q;
    frame_d      = frame_q;
    prev_d       = prev_q;
    match_cnt_d  = match_cnt_q;
    pub_flag_d   = pub_flag_q;
    out_d        = out_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    lost_cnt_d   = lost_cnt_q;
    sample       = 1'b0;
    bad_now      = bad_q;
    mask_now     = mask_q;
    match_nx     = match_cnt_q;

    if (multi_hot) begin
      bad_d   = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel != '0) begin
            state_d      = SETTLE;
            cur_sel_d    = sel;
            settle_cnt_d = '0;
          end
        end
        SETTLE: begin
          if (sel != cur_sel_q) begin
            if (sel == '0) begin
              state_d = IDLE;
            end else begin
              cur_sel_d    = sel;
              settle_cnt_d = '0;
            end
          end else if (settle_cnt_q == SETTLE_LAST) begin
            sample  = 1'b1;
            state_d = HOLD;
          end else begin
            settle_cnt_d = settle_cnt_q + 16'd1;
          end
        end
        HOLD: begin
          if (sel != cur_sel_q) begin
            if (sel == '0) begin
              state_d = IDLE;
            end else begin
              state_d      = SETTLE;
              cur_sel_d    = sel;
              settle_cnt_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The sample that fills the last slot also completes the frame.
    if (sample) begin
      frame_d.value[{idx, 2'b00} +: 4] = dec_nibble;
      frame_d.dp[idx]                  = seg_s2_q[7];
      frame_d.blank[idx]               = dec_blank;
      bad_now  = bad_q | dec_illegal;
      mask_now = mask_q | (4'b0001 << idx);
      if (mask_now == 4'hF) begin
        mask_d = '0;
        bad_d  = 1'b0;
        if (bad_now) begin
          err_d       = 1'b1;
          match_cnt_d = '0;
        end else begin
          if (frame_d == prev_q) begin
            match_nx = (match_cnt_q >= MATCH_MAX) ? MATCH_MAX : match_cnt_q + 4'd1;
          end else begin
            prev_d   = frame_d;
            match_nx = 4'd1;
          end
          match_cnt_d = match_nx;
          if ((match_nx == MATCH_MAX) && (!pub_flag_q || (frame_d != out_q))) begin
            out_d      = frame_d;
            valid_d    = 1'b1;
            pub_flag_d = 1'b1;
          end
        end
      end else begin
        mask_d = mask_now;
        bad_d  = bad_now;
      end
    end

    if (sample) begin
      lost_cnt_d = '0;
    end else if (lost_cnt_q != LOST_MAX) begin
      lost_cnt_d = lost_cnt_q + LOST_W'(1);
    end
    lost_d = (lost_cnt_d == LOST_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_s1_q     <= '0;
      sel_s2_q     <= '0;
      seg_s1_q     <= '0;
      seg_s2_q     <= '0;
      state_q      <= IDLE;
      cur_sel_q    <= '0;
      settle_cnt_q <= '0;
      mask_q       <= '0;
      bad_q        <= 1'b0;
      frame_q      <= '0;
      prev_q       <= '0;
      match_cnt_q  <= '0;
      pub_flag_q   <= 1'b0;
      out_q        <= '{value: '0, dp: '0, blank: '1};
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      lost_cnt_q   <= '0;
      lost_q       <= 1'b0;
    end else begin
      sel_s1_q     <= sel_s1_d;
      sel_s2_q     <= sel_s1_q;
      seg_s1_q     <= seg_s1_d;
      seg_s2_q     <= seg_s1_q;
      state_q      <= state_d;
      cur_sel_q    <= cur_sel_d;
      settle_cnt_q <= settle_cnt_d;
      mask_q       <= mask_d;
      bad_q        <= bad_d;
      frame_q      <= frame_d;
      prev_q       <= prev_d;
      match_cnt_q  <= match_cnt_d;
      pub_flag_q   <= pub_flag_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      lost_cnt_q   <= lost_cnt_d;
      lost_q       <= lost_d;
    end
  end

  assign value = out_q.value;
  assign dp    = out_q.dp;
  assign blank = out_q.blank;
  assign valid = valid_q;
  assign err   = err_q;
  assign lost  = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_scan_capture                                                  |
// | Self-checking bench: scanned frames in, published values scoreboarded|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  smg;
  logic [3:0]  dig;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        valid;
  logic        err;
  logic        lost;

  always #10 clk = ~clk;

  seg_scan_capture #(
    .SETTLE_CYC    (4),
    .STABLE_FRAMES (2),
    .TIMEOUT_CYC   (100),
    .SEG_ACT_LOW   (1'b1),
    .DIG_ACT_LOW   (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .smg   (smg),
    .dig   (dig),
    .value (value),
    .dp    (dp),
    .blank (blank),
    .valid (valid),
    .err   (err),
    .lost  (lost)
  );

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } exp_t;

  typedef struct {
    string           name;
    logic [3:0][7:0] frm;
    int              frames;
    int              n_valid;
    int              n_err;
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
  } rec_t;

  exp_t exp_q[$];
  rec_t recs[6];
  int   total      = 0;
  int   bad        = 0;
  int   valid_seen = 0;
  int   err_seen   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] g7(input logic [3:0] n);
    case (n)
      4'h0: g7 = 7'h3F;  4'h1: g7 = 7'h06;  4'h2: g7 = 7'h5B;  4'h3: g7 = 7'h4F;
      4'h4: g7 = 7'h66;  4'h5: g7 = 7'h6D;  4'h6: g7 = 7'h7D;  4'h7: g7 = 7'h07;
      4'h8: g7 = 7'h7F;  4'h9: g7 = 7'h6F;  4'hA: g7 = 7'h77;  4'hB: g7 = 7'h7C;
      4'hC: g7 = 7'h39;  4'hD: g7 = 7'h5E;  4'hE: g7 = 7'h79;  default: g7 = 7'h71;
    endcase
  endfunction

  // Active-low bus codes for each digit of a value.
  function automatic logic [3:0][7:0] mk_frame(input logic [15:0] v, input logic [3:0] d,
                                               input logic [3:0] b);
    logic [3:0][7:0] f;
    for (int i = 0; i < 4; i++) begin
      f[i] = ~{d[i], (b[i] ? 7'h00 : g7(v[4*i +: 4]))};
    end
    return f;
  endfunction

  function automatic logic [3:0] dsel(input int i);
    logic [3:0] one;
    one = 4'b0001 << i;
    return ~one;
  endfunction

  task automatic show(input logic [3:0] d, input logic [7:0] s, input int n);
    dig = d;
    smg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_frame(input logic [3:0][7:0] f);
    for (int i = 0; i < 4; i++) begin
      show(dsel(i), f[i], 8);
      show(4'hF, 8'hFF, 2);
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: value=%h dp=%b blank=%b, none expected", value, dp, blank);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pub_value", 32'(value), 32'(e.value));
        chk("pub_dp", 32'(dp), 32'(e.dp));
        chk("pub_blank", 32'(blank), 32'(e.blank));
      end
    end
    if (err === 1'b1) err_seen++;
    if ((valid === 1'b1) || (err === 1'b1)) chk("valid_err_excl", 32'(valid & err), 32'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0][7:0] f;
    int              v0, e0;

    recs[0] = '{"clean_1234", mk_frame(16'h1234, 4'h0, 4'h0), 3, 1, 0, 16'h1234, 4'h0, 4'h0};
    recs[1] = '{"repeat_1234", mk_frame(16'h1234, 4'h0, 4'h0), 2, 0, 0, 16'h1234, 4'h0, 4'h0};
    recs[2] = '{"blank_dp", mk_frame(16'h0005, 4'b0001, 4'b1000), 2, 1, 0, 16'h0005, 4'b0001, 4'b1000};
    f = mk_frame(16'h5678, 4'h0, 4'h0);
    f[2] = 8'hAA;
    recs[3] = '{"illegal", f, 1, 0, 1, 16'h0, 4'h0, 4'h0};
    recs[4] = '{"after_illegal", mk_frame(16'h5678, 4'h0, 4'h0), 2, 1, 0, 16'h5678, 4'h0, 4'h0};
    recs[5] = '{"abcd", mk_frame(16'hABCD, 4'h0, 4'h0), 2, 1, 0, 16'hABCD, 4'h0, 4'h0};

    rst = 1'b1;
    dig = 4'hF;
    smg = 8'hFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_blank", 32'(blank), 32'hF);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_lost", 32'(lost), 32'h0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 6; r++) begin
      v0 = valid_seen;
      e0 = err_seen;
      if (recs[r].n_valid != 0) exp_q.push_back('{recs[r].value, recs[r].dp, recs[r].blank});
      for (int k = 0; k < recs[r].frames; k++) scan_frame(recs[r].frm);
      show(4'hF, 8'hFF, 10);
      chk({recs[r].name, "_valid_cnt"}, 32'(valid_seen - v0), 32'(recs[r].n_valid));
      chk({recs[r].name, "_err_cnt"}, 32'(err_seen - e0), 32'(recs[r].n_err));
      chk({recs[r].name, "_pending"}, 32'(exp_q.size()), 32'd0);
    end

    // Too-short illegal glyph on digit 1 must never be sampled.
    f  = mk_frame(16'hABCD, 4'h0, 4'h0);
    v0 = valid_seen;
    e0 = err_seen;
    show(dsel(0), f[0], 8);
    show(4'hF, 8'hFF, 2);
    show(dsel(1), 8'hAA, 3);
    show(4'hF, 8'hFF, 2);
    for (int i = 1; i < 4; i++) begin
      show(dsel(i), f[i], 8);
      show(4'hF, 8'hFF, 2);
    end
    show(4'hF, 8'hFF, 10);
    chk("glitch_err_cnt", 32'(err_seen - e0), 32'd0);
    chk("glitch_valid_cnt", 32'(valid_seen - v0), 32'd0);

    // Multi-hot select poisons the frame in progress.
    v0 = valid_seen;
    e0 = err_seen;
    for (int i = 0; i < 2; i++) begin
      show(dsel(i), f[i], 8);
      show(4'hF, 8'hFF, 2);
    end
    show(4'b1100, f[2], 3);
    show(4'hF, 8'hFF, 2);
    for (int i = 2; i < 4; i++) begin
      show(dsel(i), f[i], 8);
      show(4'hF, 8'hFF, 2);
    end
    show(4'hF, 8'hFF, 10);
    chk("multihot_err_cnt", 32'(err_seen - e0), 32'd1);
    chk("multihot_valid_cnt", 32'(valid_seen - v0), 32'd0);

    // Timeout: silent bus raises lost, next sample drops it.
    chk("lost_before_timeout", 32'(lost), 32'd0);
    show(4'hF, 8'hFF, 100);
    @(negedge clk);
    chk("lost_after_timeout", 32'(lost), 32'd1);
    chk("lost_keeps_value", 32'(value), 32'hABCD);
    @(posedge clk);
    #1;
    v0 = valid_seen;
    scan_frame(f);
    scan_frame(f);
    @(negedge clk);
    chk("lost_cleared", 32'(lost), 32'd0);
    chk("republish_valid_cnt", 32'(valid_seen - v0), 32'd0);
    @(posedge clk);
    #1;

    // Reset after two digits captured.
    for (int i = 0; i < 2; i++) begin
      show(dsel(i), f[i], 8);
      show(4'hF, 8'hFF, 2);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_value", 32'(value), 32'h0);
    chk("mid_rst_dp", 32'(dp), 32'h0);
    chk("mid_rst_blank", 32'(blank), 32'hF);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_lost", 32'(lost), 32'h0);
    @(posedge clk);
    #1;
    v0 = valid_seen;
    e0 = err_seen;
    exp_q.push_back('{16'hABCD, 4'h0, 4'h0});
    scan_frame(f);
    scan_frame(f);
    show(4'hF, 8'hFF, 10);
    chk("post_rst_valid_cnt", 32'(valid_seen - v0), 32'd1);
    chk("post_rst_err_cnt", 32'(err_seen - e0), 32'd0);
    chk("post_rst_pending", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the reaction-test display driver: watches the multiplexed 4-digit 7-segment bus (segment lines plus digit selects) and recovers the 16-bit hex value being shown.
- Used for on-board loopback self-check and as a bench monitor.
- Sits beside the display driver and taps the same smg/dig nets; publishes the recovered value only after it is stable.

Parameters:
- SETTLE_CYC, 16, cycles a digit select must be held one-hot and unchanged before its segments are sampled (range 2..65535).
- STABLE_FRAMES, 3, consecutive identical complete frames required before publishing (range 1..15).
- TIMEOUT_CYC, 2_000_000, cycles with no digit sample before lost is raised.
- SEG_ACT_LOW, 1, segment lines active-low when 1.
- DIG_ACT_LOW, 1, digit selects active-low when 1.

Ports:
- clk    in   1   system clock, 50 MHz.
- rst    in   1   reset; synchronous, active-high.
- smg    in   8   segment lines {dp,g,f,e,d,c,b,a}.
- dig    in   4   digit selects; dig[0] drives the least-significant nibble.
- value  out  16  published hex value; nibble i comes from digit i.
- dp     out  4   published decimal-point bits per digit.
- blank  out  4   published blank flags per digit; nibble reads 0 when the digit is blank.
- valid  out  1   one-cycle pulse when value/dp/blank update.
- err    out  1   one-cycle pulse when a frame is discarded as illegal.
- lost   out  1   level, high while no digit has been sampled for TIMEOUT_CYC cycles.

Behaviour:
- Normalisation:
  - sel = DIG_ACT_LOW ? ~dig : dig.
  - seg = SEG_ACT_LOW ? ~smg : smg.
  - Both inputs pass through a 2-flop register stage first, so input-to-sample latency is SETTLE_CYC+2.
- Scan FSM:
  - IDLE: sel==0 (blanking gap). Go to SETTLE when sel is one-hot.
  - SETTLE: settle counter increments while sel is unchanged. At count SETTLE_CYC-1, sample seg into slot idx(sel), set mask[idx], and go to HOLD.
  - HOLD: wait for sel to change. On change: zero → IDLE, new one-hot → SETTLE with counter cleared.
  - Multi-hot sel in any state marks the frame bad and goes to IDLE.
  - A change of sel during SETTLE restarts SETTLE with no sample taken.
- Decode:
  - Patterns 0-F use the standard hex glyphs (0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F,0x77,0x7C,0x39,0x5E,0x79,0x71, active-high, dp masked).
  - 0x00 means blank. Any other pattern is illegal and marks the frame bad.
  - dp is captured as-is.
- Frame handling:
  - A frame completes when mask==4'b1111; the completing cycle clears mask.
  - Re-sampling a digit already in mask overwrites its slot (scan order is free).
  - Bad frame: err pulses 1 cycle after completion; match_cnt←0; prev frame is untouched.
  - Good frame equal to prev: match_cnt increments, saturating at STABLE_FRAMES.
  - Good frame not equal to prev: prev←frame, match_cnt←1.
  - When match_cnt reaches STABLE_FRAMES and frame ≠ published (or nothing published since reset), load value/dp/blank and pulse valid on the next cycle.
  - A repeat of the already-published value produces no pulse.
- Timeout: the lost counter clears on every sample. lost asserts when the counter reaches TIMEOUT_CYC and deasserts on the next sample. lost has no effect on the published value.
- Reset values: value=0, dp=0, blank=4'hF, valid=0, err=0, lost=0; FSM in IDLE; mask, match_cnt and counters all 0; published-flag cleared.
- Reset mid-frame discards partial captures. The next frame starts fresh.
- Simultaneous events: sampling the last digit and completing the frame happen in the same cycle. valid and err are never asserted together.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIG=4.
  - The 16 glyph constants and the BLANK code.
  - FSM state enum {IDLE,SETTLE,HOLD}.
- Sub-module seg7_decode, purely combinational: seg[6:0] → {illegal, blank, nibble[3:0]}.
- Everything else stays in seg_scan_capture.

Test Plan:
Bench runs with SETTLE_CYC=4, STABLE_FRAMES=2, TIMEOUT_CYC=100 and active-low buses.
- Clean scan: scan "1234" with dig 1110→1101→1011→0111, 8 cycles each, 2-cycle gaps, 3 frames → exactly one valid pulse, value=16'h1234, blank=0, dp=0; no further pulse on frames 3+.
- Blank and dp: digit3 smg=8'hFF, digit0 shows '5' with dp (smg=8'h12) → value=16'h0005, blank=4'b1000, dp=4'b0001.
- Illegal glyph: digit2 smg=8'hAA for one frame → err pulse; no valid pulse; next 2 clean frames → valid.
- Glitch rejection: dig changes after 3 cycles (< SETTLE_CYC) → no sample taken. Multi-hot dig=4'b1100 → frame bad → err.
- Change and timeout: switch shown value to "ABCD" → valid after 2 matching frames, value=16'hABCD. Then hold dig=4'hF for 100 cycles → lost=1; resume scanning → lost=0.
- Reset mid-frame: assert rst after 2 digits captured → all outputs return to reset values; next 2 full frames publish normally.
